// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ==== dmem_port_arbiter: core/external arbiter for the single-port data memory, rev 1.0 ====
// ==== Define DMEM_ARB_STATS_EN to enable the stall_cycles_o / ext_accesses_o counters    ====
module dmem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_mem_read_i,
  input  logic                  core_mem_write_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  ext_req_i,
  input  logic                  ext_we_i,
  input  logic [ADDR_WIDTH-1:0] ext_addr_i,
  input  logic [DATA_WIDTH-1:0] ext_wdata_i,
  output logic                  ext_gnt_o,
  output logic                  ext_rvalid_o,
  output logic [DATA_WIDTH-1:0] ext_rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           ext_accesses_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    S_CORE = 1'b0,
    S_EXT  = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [SW-1:0]   starve_cnt;
  logic [BW-1:0]   burst_cnt;
  logic            core_req;

  assign core_req     = core_mem_read_i | core_mem_write_i;
  assign core_rdata_o = mem_rdata_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_CORE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    ext_gnt_o    = 1'b0;
    core_stall_o = 1'b0;
    mem_write_o  = core_mem_write_i;
    mem_read_o   = core_mem_read_i & ~core_mem_write_i;
    mem_addr_o   = core_addr_i;
    mem_wdata_o  = core_wdata_i;
    case (state)
      S_CORE: begin
        if (ext_req_i && (!core_req || starve_cnt == STARVE_MAX)) begin
          next_state = S_EXT;
        end
      end
      S_EXT: begin
        ext_gnt_o    = ext_req_i;
        core_stall_o = core_req;
        mem_write_o  = ext_req_i & ext_we_i;
        mem_read_o   = ext_req_i & ~ext_we_i;
        mem_addr_o   = ext_addr_i;
        mem_wdata_o  = ext_wdata_i;
        if (!ext_req_i || (core_req && burst_cnt == BURST_LAST)) begin
          next_state = S_CORE;
        end
      end
      default: next_state = S_CORE;
    endcase
  end

  // Starvation only accrues while ext is actually being held off by core traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == S_EXT || !ext_req_i || next_state == S_EXT) begin
      starve_cnt <= '0;
    end else if (core_req && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (state == S_CORE || !core_req) begin
      burst_cnt <= '0;
    end else if (ext_gnt_o) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_rvalid_o <= 1'b0;
      ext_rdata_o  <= '0;
    end else begin
      ext_rvalid_o <= ext_gnt_o & ~ext_we_i;
      if (ext_gnt_o && !ext_we_i) begin
        ext_rdata_o <= mem_rdata_i;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_o <= '0;
      ext_accesses_o <= '0;
    end else begin
      if (core_stall_o) begin
        stall_cycles_o <= stall_cycles_o + 32'd1;
      end
      if (ext_gnt_o) begin
        ext_accesses_o <= ext_accesses_o + 32'd1;
      end
    end
  end
`else
  assign stall_cycles_o = '0;
  assign ext_accesses_o = '0;
`endif

endmodule
`default_nettype wire
